// File: rtl/zprize_mul_pkg.sv
// Shared definitions for the limb-product column accumulator.
//   - default operand / limb / column / metadata widths
//   - FSM state encoding for the accumulator
//   - clog2 helper usable in parameter expressions
package zprize_mul_pkg;

    localparam int unsigned OP_W    = 384;  // operand width; product is 2*OP_W
    localparam int unsigned LIMB_W  = 26;   // limb width; limb products are 2*LIMB_W
    localparam int unsigned N_LIMBS = 15;   // limbs per operand
    localparam int unsigned COL_W   = 32;   // column register width (limb + guard bits)
    localparam int unsigned META_W  = 32;   // metadata width

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        NORM,
        WAIT
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/zprize_mul_col_acc_if.sv
// Handshake bundle between the multiplier stage and the column accumulator.
//   in_*      : partial-product beat stream (no backpressure; issuer checks in_ready)
//   out_*     : normalised product on a valid/ready handshake
//   err       : sticky protocol / range error flag
// master = issuer + downstream consumer side, slave = accumulator.
interface zprize_mul_col_acc_if #(
    parameter int unsigned W  = 384,
    parameter int unsigned LW = 26,
    parameter int unsigned M  = 32,
    parameter int unsigned CI = 5
) ();
    logic              in_valid;
    logic [2*LW-1:0]   in_prod;
    logic [CI-1:0]     in_col;
    logic              in_first;
    logic              in_last;
    logic [M-1:0]      in_m;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    out_prod;
    logic [M-1:0]      out_m;
    logic              err;

    modport master (
        output in_valid, in_prod, in_col, in_first, in_last, in_m, out_ready,
        input  in_ready, out_valid, out_prod, out_m, err
    );

    modport slave (
        input  in_valid, in_prod, in_col, in_first, in_last, in_m, out_ready,
        output in_ready, out_valid, out_prod, out_m, err
    );
endinterface

// File: rtl/zprize_col_norm.sv
// One carry-propagate step of the normalisation pass.
//   col       in  CW      column carry-save value
//   carry_in  in  CW-LW+1 carry from the previous column
//   digit     out LW      normalised digit for this column
//   carry_out out CW-LW+1 carry into the next column
// Purely combinational; the parent registers digit and carry.
module zprize_col_norm
    import zprize_mul_pkg::*;
#(
    parameter int unsigned LW = LIMB_W,
    parameter int unsigned CW = COL_W
) (
    input  logic [CW-1:0]  col,
    input  logic [CW-LW:0] carry_in,
    output logic [LW-1:0]  digit,
    output logic [CW-LW:0] carry_out
);
    logic [CW:0] sum;

    always_comb begin
        sum       = {1'b0, col} + (CW+1)'(carry_in);
        digit     = sum[LW-1:0];
        carry_out = sum[CW:LW];
    end
endmodule

// File: rtl/zprize_mul_col_acc.sv
// Column accumulator for limb partial products.
//   clk, rst  : clock, synchronous active-low reset
//   bus       : slave side of zprize_mul_col_acc_if (beat stream in,
//               normalised 2*W-bit product + metadata out, sticky err)
// Beats add their low/high limb halves into columns k and k+1. After the
// last beat, columns are carry-normalised one per cycle into a result
// shift register, then loaded into the output slot (or held in WAIT until
// the slot frees).
module zprize_mul_col_acc
    import zprize_mul_pkg::*;
#(
    parameter int unsigned W  = OP_W,
    parameter int unsigned LW = LIMB_W,
    parameter int unsigned NL = N_LIMBS,
    parameter int unsigned CW = COL_W,
    parameter int unsigned M  = META_W,
    parameter int unsigned CI = clog2(2 * NL)
) (
    input logic                  clk,
    input logic                  rst,
    zprize_mul_col_acc_if.slave  bus
);
    localparam int unsigned NC = 2 * NL;
    localparam int unsigned RW = NC * LW;
    localparam int unsigned KW = CW - LW + 1;
    localparam int unsigned NW = clog2(NC + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q [NC];
    logic [CW-1:0]   col_d [NC];
    logic [KW-1:0]   carry_q, carry_d;
    logic [NW-1:0]   n_q, n_d;
    logic [RW-1:0]   res_q, res_d;
    logic [M-1:0]    m_q, m_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [2*W-1:0]  out_prod_q, out_prod_d;
    logic [M-1:0]    out_m_q, out_m_d;
    logic            err_q, err_d;

    logic [CW-1:0]   norm_col;
    logic [LW-1:0]   norm_digit;
    logic [KW-1:0]   norm_carry;
    logic [CW-1:0]   prod_lo, prod_hi;
    logic            col_ok, take, beat, norm_done, slot_free, load;

    zprize_col_norm #(
        .LW (LW),
        .CW (CW)
    ) u_norm (
        .col       (norm_col),
        .carry_in  (carry_q),
        .digit     (norm_digit),
        .carry_out (norm_carry)
    );

    always_comb begin
        col_ok    = bus.in_col <= CI'(NC - 2);
        take      = bus.in_valid && in_ready_q;
        beat      = take && col_ok;
        prod_lo   = CW'(bus.in_prod[LW-1:0]);
        prod_hi   = CW'(bus.in_prod[2*LW-1:LW]);
        // n_q reaches NC one cycle after the last digit; that cycle does the load.
        norm_done = (n_q == NW'(NC));
        slot_free = !out_valid_q || bus.out_ready;

        norm_col = '0;
        for (int unsigned c = 0; c < NC; c++) begin
            if (n_q == NW'(c)) norm_col = col_q[c];
        end

        state_d     = state_q;
        carry_d     = carry_q;
        n_d         = n_q;
        res_d       = res_q;
        m_d         = m_q;
        out_valid_d = out_valid_q;
        out_prod_d  = out_prod_q;
        out_m_d     = out_m_q;
        err_d       = err_q;
        load        = 1'b0;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if ((bus.in_valid && !in_ready_q) || (take && !col_ok)) err_d = 1'b1;

        // First beat clears every column, so k and k+1 load instead of add.
        for (int unsigned c = 0; c < NC; c++) begin
            col_d[c] = (beat && bus.in_first) ? '0 : col_q[c];
            if (beat && bus.in_col == CI'(c)) col_d[c] = col_d[c] + prod_lo;
            if (beat && c > 0 && bus.in_col == CI'(c - 1)) col_d[c] = col_d[c] + prod_hi;
        end

        case (state_q)
            IDLE, ACC: begin
                if (beat) begin
                    if (state_q == IDLE && !bus.in_first) err_d = 1'b1;
                    if (bus.in_last) begin
                        state_d = NORM;
                        m_d     = bus.in_m;
                        n_d     = '0;
                        carry_d = '0;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            NORM: begin
                if (!norm_done) begin
                    res_d   = {norm_digit, res_q[RW-1:LW]};
                    carry_d = norm_carry;
                    n_d     = n_q + 1'b1;
                end else if (slot_free) begin
                    load    = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (slot_free) load = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_prod_d  = res_q[2*W-1:0];
            out_m_d     = m_q;
            state_d     = IDLE;
        end

        in_ready_d = (state_d == IDLE) || (state_d == ACC);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            for (int unsigned c = 0; c < NC; c++) col_q[c] <= '0;
            carry_q     <= '0;
            n_q         <= '0;
            res_q       <= '0;
            m_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
            out_m_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            carry_q     <= carry_d;
            n_q         <= n_d;
            res_q       <= res_d;
            m_q         <= m_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_prod_q  <= out_prod_d;
            out_m_q     <= out_m_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_prod  = out_prod_q;
    assign bus.out_m     = out_m_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_zprize_mul_col_acc.sv
// Scoreboard bench: dut_a is a small NL=2 / W=52 instance, dut_b uses the
// default 15-limb / 384-bit configuration. Expected results are queued at
// issue time; a negedge monitor compares every valid output cycle against
// the queue head and pops on handshake.
module tb_zprize_mul_col_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    zprize_mul_col_acc_if #(.W(52),  .LW(26), .M(32), .CI(2)) ia ();
    zprize_mul_col_acc_if #(.W(384), .LW(26), .M(32), .CI(5)) ib ();

    zprize_mul_col_acc #(.W(52), .LW(26), .NL(2), .CW(32), .M(32), .CI(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia.slave)
    );

    zprize_mul_col_acc #(.W(384), .LW(26), .NL(15), .CW(32), .M(32), .CI(5)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib.slave)
    );

    typedef struct packed {
        logic [767:0] prod;
        logic [31:0]  m;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned t_last [2];
    int unsigned lat_chk[2];
    logic        pv     [2];

    task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic r,
                       input logic [767:0] p, input logic [31:0] m);
        exp_t e;
        int   qs;
        qs = (id == 0) ? qa.size() : qb.size();
        if (v) begin
            if (!pv[id] && lat_chk[id] != 0)
                check($sformatf("latency%0d", id), 768'(cyc - t_last[id]), 768'(lat_chk[id]));
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out%0d: got %0h expected no result", id, p);
            end else begin
                e = (id == 0) ? qa[0] : qb[0];
                check($sformatf("out_prod%0d", id), p, e.prod);
                check($sformatf("out_m%0d", id), 768'(m), 768'(e.m));
                if (r) begin
                    if (id == 0) void'(qa.pop_front());
                    else         void'(qb.pop_front());
                end
            end
        end
        pv[id] = v;
    endtask

    always @(negedge clk) begin
        mon(0, ia.out_valid, ia.out_ready, 768'(ia.out_prod), ia.out_m);
        mon(1, ib.out_valid, ib.out_ready, 768'(ib.out_prod), ib.out_m);
    end

    task automatic send(input int id, input int col, input logic [51:0] prod,
                        input logic first, input logic last, input logic [31:0] m);
        if (id == 0) begin
            ia.in_valid = 1'b1; ia.in_col = 2'(col); ia.in_prod = prod;
            ia.in_first = first; ia.in_last = last; ia.in_m = m;
        end else begin
            ib.in_valid = 1'b1; ib.in_col = 5'(col); ib.in_prod = prod;
            ib.in_first = first; ib.in_last = last; ib.in_m = m;
        end
        @(posedge clk);
        #1;
        if (last) t_last[id] = cyc;
        ia.in_valid = 1'b0;
        ib.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int id, input int budget);
        int n;
        n = 0;
        while (((id == 0) ? qa.size() : qb.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check($sformatf("drain%0d pending", id),
              768'((id == 0) ? qa.size() : qb.size()), 768'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [25:0]  li, lj;
        logic [103:0] e104;
        logic [51:0]  ones_sq;
        exp_t         e;

        pv[0] = 1'b0; pv[1] = 1'b0;
        lat_chk[0] = 0; lat_chk[1] = 0;
        t_last[0] = 0; t_last[1] = 0;
        ia.in_valid = 1'b0; ia.in_prod = '0; ia.in_col = '0; ia.in_first = 1'b0;
        ia.in_last = 1'b0; ia.in_m = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_prod = '0; ib.in_col = '0; ib.in_first = 1'b0;
        ib.in_last = 1'b0; ib.in_m = '0; ib.out_ready = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset state
        check("rst_a in_ready",  768'(ia.in_ready),  768'(1));
        check("rst_a out_valid", 768'(ia.out_valid), 768'(0));
        check("rst_a err",       768'(ia.err),       768'(0));
        check("rst_a out_prod",  768'(ia.out_prod),  768'(0));
        check("rst_b in_ready",  768'(ib.in_ready),  768'(1));
        check("rst_b out_valid", 768'(ib.out_valid), 768'(0));
        check("rst_b out_m",     768'(ib.out_m),     768'(0));

        // Single-beat op: 2^52-1 at column 0, latency 1+2*NL = 5
        e.prod = 768'(52'hF_FFFF_FFFF_FFFF); e.m = 32'hA5A5_0001;
        qa.push_back(e);
        lat_chk[0] = 5;
        send(0, 0, 52'hF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 32'hA5A5_0001);
        wait_drain(0, 20);

        // Carry stress: (2^52-1)^2 via all-ones limbs
        ones_sq = 52'(26'h3FF_FFFF) * 52'(26'h3FF_FFFF);
        e104    = 104'(1) - (104'(1) << 53);
        e.prod  = 768'(e104); e.m = 32'h0000_0C01;
        qa.push_back(e);
        send(0, 0, ones_sq, 1'b1, 1'b0, 32'h0);
        send(0, 1, ones_sq, 1'b0, 1'b0, 32'h0);
        send(0, 1, ones_sq, 1'b0, 1'b0, 32'h0);
        send(0, 2, ones_sq, 1'b0, 1'b1, 32'h0000_0C01);
        wait_drain(0, 20);

        // All-ones digits in both halves at columns 0..2; overflow past 2W discarded
        e104   = 104'(26'h3FF_FFFF) * (104'(1) + (104'(1) << 26))
               * (104'(1) + (104'(1) << 26) + (104'(1) << 52));
        e.prod = 768'(e104); e.m = 32'h0000_0C02;
        qa.push_back(e);
        send(0, 0, 52'hF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 32'h0);
        send(0, 1, 52'hF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 32'h0);
        send(0, 2, 52'hF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 32'h0000_0C02);
        wait_drain(0, 20);

        // Backpressure: first result held, second op parks in WAIT
        ia.out_ready = 1'b0;
        e.prod = 768'(52'h1_2345_6789_ABCD); e.m = 32'h0000_0B01;
        qa.push_back(e);
        send(0, 0, 52'h1_2345_6789_ABCD, 1'b1, 1'b1, 32'h0000_0B01);
        repeat (8) @(posedge clk);
        #1;
        lat_chk[0] = 0;
        e.prod = 768'(52'h77) << 26; e.m = 32'h0000_0B02;
        qa.push_back(e);
        send(0, 1, 52'h77, 1'b1, 1'b1, 32'h0000_0B02);
        repeat (41) @(posedge clk);
        #1;
        check("bp in_ready (WAIT)", 768'(ia.in_ready),  768'(0));
        check("bp out_valid held",  768'(ia.out_valid), 768'(1));
        ia.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ia.out_ready = 1'b0;
        check("bp second valid",    768'(ia.out_valid), 768'(1));
        check("bp second m",        768'(ia.out_m),     768'(32'h0000_0B02));
        check("bp back to IDLE",    768'(ia.in_ready),  768'(1));
        repeat (3) @(posedge clk);
        #1;
        ia.out_ready = 1'b1;
        wait_drain(0, 20);

        // Out-of-range column: dropped, err set, no op started
        lat_chk[0] = 0;
        send(0, 3, 52'h5, 1'b1, 1'b1, 32'h0);
        check("range err",      768'(ia.err),      768'(1));
        check("range in_ready", 768'(ia.in_ready), 768'(1));
        repeat (10) @(posedge clk);
        #1;

        // Reset mid-NORM, then a fresh 3*5 op
        send(0, 0, 52'd99, 1'b1, 1'b1, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        check("midrst out_valid", 768'(ia.out_valid), 768'(0));
        check("midrst err",       768'(ia.err),       768'(0));
        check("midrst in_ready",  768'(ia.in_ready),  768'(1));
        check("midrst out_prod",  768'(ia.out_prod),  768'(0));
        repeat (10) @(posedge clk);
        #1;
        e.prod = 768'(15); e.m = 32'h0000_0D01;
        qa.push_back(e);
        lat_chk[0] = 5;
        send(0, 0, 52'd15, 1'b1, 1'b1, 32'h0000_0D01);
        wait_drain(0, 20);

        // Full 15x15 schoolbook, a = b = 2^384-1, plus a stray beat during NORM
        e.prod = 768'(1) - (768'(1) << 385); e.m = 32'hDEAD_BEEF;
        qb.push_back(e);
        lat_chk[1] = 31;
        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < 15; j++) begin
                li = (i < 14) ? 26'h3FF_FFFF : 26'h00F_FFFF;
                lj = (j < 14) ? 26'h3FF_FFFF : 26'h00F_FFFF;
                send(1, i + j, 52'(li) * 52'(lj), (i == 0 && j == 0), (i == 14 && j == 14),
                     32'hDEAD_BEEF);
            end
        end
        check("school err clear", 768'(ib.err), 768'(0));
        repeat (3) @(posedge clk);
        #1;
        send(1, 3, 52'h5, 1'b0, 1'b0, 32'h0);
        check("norm beat err",      768'(ib.err),      768'(1));
        check("norm beat in_ready", 768'(ib.in_ready), 768'(0));
        wait_drain(1, 100);
        check("err sticky", 768'(ib.err), 768'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
